// File: rtl/sbox_layer_serial.sv
// Serialised 4-bit S-box layer: substitutes LANES nibbles per cycle, MSB nibble first,
// using the forward or inverse table chosen when the block is accepted.
module sbox_layer_serial #(
  parameter int BLOCK_W = 64,
  parameter int LANES   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] in_data,
  input  logic               in_decrypt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] out_data,
  output logic               busy
);

  localparam int NIB   = BLOCK_W / 4;
  localparam int STEPS = NIB / LANES;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [CW-1:0] CNT_LAST = CW'(STEPS - 1);

  if (!(BLOCK_W == 64 || BLOCK_W == 128)) begin : g_bad_block_w
    $error("sbox_layer_serial: BLOCK_W must be 64 or 128");
  end
  if (LANES < 1 || (NIB % LANES) != 0) begin : g_bad_lanes
    $error("sbox_layer_serial: LANES must divide BLOCK_W/4");
  end

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [BLOCK_W-1:0] data_q, data_d;
  logic               mode_q, mode_d;
  logic [BLOCK_W-1:0] sub_data;

  function automatic logic [3:0] sbox_lookup(input logic [3:0] n, input logic inv);
    logic [3:0] r;
    r = 4'h0;
    if (!inv) begin
      case (n)
        4'h0: r = 4'hC;  4'h1: r = 4'h5;  4'h2: r = 4'h6;  4'h3: r = 4'hB;
        4'h4: r = 4'h9;  4'h5: r = 4'h0;  4'h6: r = 4'hA;  4'h7: r = 4'hD;
        4'h8: r = 4'h3;  4'h9: r = 4'hE;  4'hA: r = 4'hF;  4'hB: r = 4'h8;
        4'hC: r = 4'h4;  4'hD: r = 4'h7;  4'hE: r = 4'h1;  default: r = 4'h2;
      endcase
    end else begin
      case (n)
        4'h0: r = 4'h5;  4'h1: r = 4'hE;  4'h2: r = 4'hF;  4'h3: r = 4'h8;
        4'h4: r = 4'hC;  4'h5: r = 4'h1;  4'h6: r = 4'h2;  4'h7: r = 4'hD;
        4'h8: r = 4'hB;  4'h9: r = 4'h4;  4'hA: r = 4'h6;  4'hB: r = 4'h3;
        4'hC: r = 4'h0;  4'hD: r = 4'h7;  4'hE: r = 4'h9;  default: r = 4'hA;
      endcase
    end
    return r;
  endfunction

  // Only LANES lookups exist; the step counter steers them onto the current window.
  always_comb begin
    sub_data = data_q;
    for (int l = 0; l < LANES; l++) begin
      int base;
      base = (NIB - 1 - int'(cnt_q) * LANES - l) * 4;
      sub_data[base +: 4] = sbox_lookup(data_q[base +: 4], mode_q);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    mode_d  = mode_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          data_d  = in_data;
          mode_d  = in_decrypt;
          cnt_d   = '0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        data_d = sub_data;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      mode_q  <= mode_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign out_data  = data_q;

endmodule

// File: tb/tb_sbox_layer_serial.sv
// Bench for sbox_layer_serial: five instances covering LANES 1/2/4/16/32 at 64 and 128 bits,
// checked against a nibble-table reference model.
module tb_sbox_layer_serial;

  localparam logic [3:0] FWD [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                      4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
  localparam logic [3:0] INV [16] = '{4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
                                      4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA};
  localparam int NDUT = 5;
  localparam int WIDTHS [NDUT] = '{64, 64, 128, 128, 128};
  localparam int STEPSV [NDUT] = '{4, 16, 16, 2, 1};

  logic clk;
  logic rst;
  logic         in_valid_a   [NDUT];
  logic         in_decrypt_a [NDUT];
  logic         out_ready_a  [NDUT];
  logic [127:0] in_data_a    [NDUT];
  logic         in_ready_a   [NDUT];
  logic         out_valid_a  [NDUT];
  logic         busy_a       [NDUT];
  logic [127:0] od_all       [NDUT];
  logic [63:0]  od0, od1;
  logic [127:0] od2, od3, od4;

  int tests;
  int failed;

  sbox_layer_serial #(.BLOCK_W(64), .LANES(4)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid_a[0]), .in_ready(in_ready_a[0]),
    .in_data(in_data_a[0][63:0]), .in_decrypt(in_decrypt_a[0]), .out_valid(out_valid_a[0]),
    .out_ready(out_ready_a[0]), .out_data(od0), .busy(busy_a[0]));
  sbox_layer_serial #(.BLOCK_W(64), .LANES(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid_a[1]), .in_ready(in_ready_a[1]),
    .in_data(in_data_a[1][63:0]), .in_decrypt(in_decrypt_a[1]), .out_valid(out_valid_a[1]),
    .out_ready(out_ready_a[1]), .out_data(od1), .busy(busy_a[1]));
  sbox_layer_serial #(.BLOCK_W(128), .LANES(2)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid_a[2]), .in_ready(in_ready_a[2]),
    .in_data(in_data_a[2]), .in_decrypt(in_decrypt_a[2]), .out_valid(out_valid_a[2]),
    .out_ready(out_ready_a[2]), .out_data(od2), .busy(busy_a[2]));
  sbox_layer_serial #(.BLOCK_W(128), .LANES(16)) u3 (
    .clk(clk), .rst(rst), .in_valid(in_valid_a[3]), .in_ready(in_ready_a[3]),
    .in_data(in_data_a[3]), .in_decrypt(in_decrypt_a[3]), .out_valid(out_valid_a[3]),
    .out_ready(out_ready_a[3]), .out_data(od3), .busy(busy_a[3]));
  sbox_layer_serial #(.BLOCK_W(128), .LANES(32)) u4 (
    .clk(clk), .rst(rst), .in_valid(in_valid_a[4]), .in_ready(in_ready_a[4]),
    .in_data(in_data_a[4]), .in_decrypt(in_decrypt_a[4]), .out_valid(out_valid_a[4]),
    .out_ready(out_ready_a[4]), .out_data(od4), .busy(busy_a[4]));

  assign od_all[0] = {64'h0, od0};
  assign od_all[1] = {64'h0, od1};
  assign od_all[2] = od2;
  assign od_all[3] = od3;
  assign od_all[4] = od4;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: every nibble of the block goes through the selected table.
  function automatic logic [127:0] model(input logic [127:0] x, input int width, input logic dec);
    logic [127:0] r;
    logic [3:0]   n;
    r = '0;
    for (int k = 0; k < width / 4; k++) begin
      n = x[4*k +: 4];
      r[4*k +: 4] = dec ? INV[n] : FWD[n];
    end
    return r;
  endfunction

  function automatic logic [127:0] rand_block(input int width);
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    if (width == 64) r[127:64] = '0;
    return r;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Feeds one block to instance d, then returns the result and the cycles from accept to out_valid.
  task automatic run_block(input int d, input logic [127:0] data, input logic dec,
                           output logic [127:0] res, output int lat);
    in_data_a[d]    = data;
    in_decrypt_a[d] = dec;
    in_valid_a[d]   = 1'b1;
    out_ready_a[d]  = 1'b0;
    check("in_ready_idle", 128'(in_ready_a[d]), 128'(1'b1));
    tick();
    in_valid_a[d]   = 1'b0;
    in_data_a[d]    = rand_block(WIDTHS[d]);
    in_decrypt_a[d] = ~dec;
    lat = 0;
    while (!out_valid_a[d] && lat < 200) begin
      tick();
      lat++;
    end
    check("out_valid_timeout", 128'(out_valid_a[d]), 128'(1'b1));
    res = od_all[d];
    if (out_valid_a[d]) begin
      out_ready_a[d] = 1'b1;
      tick();
      out_ready_a[d] = 1'b0;
    end
  endtask

  initial begin
    logic [127:0] res, res2, x, exp;
    int lat, d;
    tests  = 0;
    failed = 0;
    rst    = 1'b1;
    for (int i = 0; i < NDUT; i++) begin
      in_valid_a[i]   = 1'b0;
      in_decrypt_a[i] = 1'b0;
      out_ready_a[i]  = 1'b0;
      in_data_a[i]    = '0;
    end
    repeat (3) tick();
    rst = 1'b0;

    check("rst_in_ready", 128'(in_ready_a[0]), 128'(1'b1));
    check("rst_out_valid", 128'(out_valid_a[0]), 128'(1'b0));
    check("rst_busy", 128'(busy_a[0]), 128'(1'b0));
    check("rst_out_data", od_all[0], 128'h0);
    check("rst_out_data_128", od_all[2], 128'h0);

    // T1: zero block forward, latency equals STEPS
    run_block(0, 128'h0, 1'b0, res, lat);
    check("t1_data", res, 128'hCCCC_CCCC_CCCC_CCCC);
    check("t1_latency", 128'(lat), 128'(4));

    // T2: known inverse vector
    run_block(0, 128'h0123_4567_89AB_CDEF, 1'b1, res, lat);
    check("t2_data", res, 128'h5EF8_C12D_B463_079A);

    // T3: random round trips across all instances
    for (int i = 0; i < 1000; i++) begin
      d = i % NDUT;
      x = rand_block(WIDTHS[d]);
      run_block(d, x, 1'b0, res, lat);
      check("t3_enc", res, model(x, WIDTHS[d], 1'b0));
      check("t3_enc_latency", 128'(lat), 128'(STEPSV[d]));
      run_block(d, res, 1'b1, res2, lat);
      check("t3_roundtrip", res2, x);
    end

    // T4: backpressure holds the result stable
    x   = rand_block(64);
    exp = model(x, 64, 1'b0);
    in_data_a[0] = x; in_decrypt_a[0] = 1'b0; in_valid_a[0] = 1'b1;
    tick();
    in_valid_a[0] = 1'b0;
    lat = 0;
    while (!out_valid_a[0] && lat < 200) begin
      tick();
      lat++;
    end
    for (int c = 0; c < 10; c++) begin
      check("t4_out_valid", 128'(out_valid_a[0]), 128'(1'b1));
      check("t4_out_data", od_all[0], exp);
      check("t4_in_ready", 128'(in_ready_a[0]), 128'(1'b0));
      check("t4_busy", 128'(busy_a[0]), 128'(1'b1));
      tick();
    end
    out_ready_a[0] = 1'b1;
    tick();
    out_ready_a[0] = 1'b0;
    check("t4_back_idle", 128'(in_ready_a[0]), 128'(1'b1));

    // T5: reset during the second BUSY cycle
    in_data_a[0] = rand_block(64); in_decrypt_a[0] = 1'b0; in_valid_a[0] = 1'b1;
    tick();
    in_valid_a[0] = 1'b0;
    check("t5_busy", 128'(busy_a[0]), 128'(1'b1));
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_in_ready", 128'(in_ready_a[0]), 128'(1'b1));
    check("t5_out_valid", 128'(out_valid_a[0]), 128'(1'b0));
    check("t5_busy_low", 128'(busy_a[0]), 128'(1'b0));
    x = rand_block(64);
    run_block(0, x, 1'b1, res, lat);
    check("t5_fresh", res, model(x, 64, 1'b1));
    check("t5_fresh_latency", 128'(lat), 128'(4));

    // T6: single-step instance
    run_block(4, {128{1'b1}}, 1'b0, res, lat);
    check("t6_data", res, {32{4'h2}});
    check("t6_latency", 128'(lat), 128'(1));
    in_data_a[4] = rand_block(128); in_decrypt_a[4] = 1'b0; in_valid_a[4] = 1'b1;
    tick();
    in_valid_a[4] = 1'b0;
    check("t6_cnt_busy", 128'(u4.cnt_q), 128'(0));
    tick();
    check("t6_cnt_done", 128'(u4.cnt_q), 128'(0));
    out_ready_a[4] = 1'b1;
    tick();
    out_ready_a[4] = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
